muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit that sits between the register file read ports and its write port.
- Consumes rs1/rs2 operands read from the register file.
- Produces a 32-bit result plus a one-cycle write-back request (address, enable, data) that drives the register file's RegWrite/A3/WD3.
- Raises busy so the control unit can stall the PC while an M-extension instruction executes.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_if.sv | 31 +++
 rtl/muldiv_datapath.sv | 109 ++++++++++
 rtl/muldiv_unit.sv | 105 ++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_pkg : shared constants and types for the RV32M muldiv unit  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_if : launch / write-back bundle of the muldiv unit          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_addr;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            wb_en;
  logic [4:0]      wb_addr;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_addr,
    input  busy, done, result, wb_en, wb_addr
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_addr,
    output busy, done, result, wb_en, wb_addr
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_datapath : shift-add multiply / restoring divide with sign  |
// | fix-up and early-out special-case results.   Rev 1.0               |
// +--------------------------------------------------------------------+
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            load_i,
  input  wire logic            step_i,
  input  wire logic            is_div_i,
  input  wire logic [2:0]      funct3_i,
  input  wire logic [2:0]      op_i,
  input  wire logic [XLEN-1:0] rs1_i,
  input  wire logic [XLEN-1:0] rs2_i,
  output logic                 special_o,
  output logic [XLEN-1:0]      result_o
);

  localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // a_q: multiplicand (mul) or dividend/quotient shift register (div)
  logic [2*XLEN-1:0] a_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   spec_val_q;
  logic              neg_q;
  logic              spec_q;

  logic              w_rs1_signed;
  logic              w_rs2_signed;
  logic              w_sa;
  logic              w_sb;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic [XLEN-1:0]   w_spec_val;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mres;
  logic [XLEN-1:0]   w_dres;
  logic [XLEN-1:0]   w_dres_s;

  always_comb begin
    w_rs1_signed = (funct3_i != F3_MULHU) && !(funct3_i[2] && funct3_i[0]);
    w_rs2_signed = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
    w_sa         = w_rs1_signed && rs1_i[XLEN-1];
    w_sb         = w_rs2_signed && rs2_i[XLEN-1];
    w_mag1       = w_sa ? -rs1_i : rs1_i;
    w_mag2       = w_sb ? -rs2_i : rs2_i;
    w_div0       = funct3_i[2] && (rs2_i == '0);
    w_ovf        = funct3_i[2] && !funct3_i[0] && (rs1_i == C_MIN) && (rs2_i == '1);
    special_o    = w_div0 || w_ovf;
    w_spec_val   = w_div0 ? (funct3_i[1] ? rs1_i : '1)
                          : (funct3_i[1] ? '0 : C_MIN);

    w_rem_sh     = {acc_q[XLEN-1:0], a_q[XLEN-1]};
    w_diff       = w_rem_sh - {1'b0, b_q};

    w_prod       = neg_q ? -acc_q : acc_q;
    w_mres       = (op_i[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    w_dres       = op_i[1] ? acc_q[XLEN-1:0] : a_q[XLEN-1:0];
    w_dres_s     = neg_q ? -w_dres : w_dres;
    result_o     = spec_q ? spec_val_q : (op_i[2] ? w_dres_s : w_mres);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      spec_val_q <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
    end else if (load_i) begin
      a_q        <= {{XLEN{1'b0}}, w_mag1};
      b_q        <= w_mag2;
      acc_q      <= '0;
      // Remainder takes the dividend's sign; everything else takes sa^sb.
      neg_q      <= (funct3_i[2] && funct3_i[1]) ? w_sa : (w_sa ^ w_sb);
      spec_q     <= special_o;
      spec_val_q <= w_spec_val;
    end else if (step_i) begin
      if (is_div_i) begin
        if (!w_diff[XLEN]) begin
          acc_q <= {{XLEN{1'b0}}, w_diff[XLEN-1:0]};
          a_q   <= {a_q[2*XLEN-2:0], 1'b1};
        end else begin
          acc_q <= {{XLEN{1'b0}}, w_rem_sh[XLEN-1:0]};
          a_q   <= {a_q[2*XLEN-2:0], 1'b0};
        end
      end else begin
        if (b_q[0]) begin
          acc_q <= acc_q + a_q;
        end
        a_q <= {a_q[2*XLEN-2:0], 1'b0};
        b_q <= {1'b0, b_q[XLEN-1:1]};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M multiply/divide unit with register   |
// | file write-back and stall (busy) output.   Rev 1.0                 |
// +--------------------------------------------------------------------+
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = muldiv_pkg::XLEN,
  parameter int CNT_W = muldiv_pkg::CNT_W
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  muldiv_if.slave    bus
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic             done_q;
  logic             wb_en_q;
  logic [4:0]       wb_addr_q;

  logic             w_load;
  logic             w_step;
  logic             w_special;
  logic [XLEN-1:0]  w_result;

  assign w_load = (state_q == S_IDLE) && bus.start;
  assign w_step = (state_q == S_CALC);

  muldiv_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (w_load),
    .step_i    (w_step),
    .is_div_i  (f3_q[2]),
    .funct3_i  (bus.funct3),
    .op_i      (f3_q),
    .rs1_i     (bus.rs1_data),
    .rs2_i     (bus.rs2_data),
    .special_o (w_special),
    .result_o  (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q  <= 1'b0;
          wb_en_q <= 1'b0;
          if (bus.start) begin
            f3_q      <= bus.funct3;
            wb_addr_q <= bus.rd_addr;
            cnt_q     <= '0;
            if (w_special) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              wb_en_q <= (bus.rd_addr != 5'd0);
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            wb_en_q <= (wb_addr_q != 5'd0);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          wb_en_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          wb_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.result  = w_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_muldiv_unit : directed vectors with queued expectations checked |
// | by an independent done monitor.   Rev 1.0                          |
// +--------------------------------------------------------------------+
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        wb_en;
    logic [4:0]  addr;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", {31'b0, bus.done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_result"},  bus.result, e.res);
        chk({e.name, "_wb_en"},   {31'b0, bus.wb_en}, {31'b0, e.wb_en});
        chk({e.name, "_wb_addr"}, {27'b0, bus.wb_addr}, {27'b0, e.addr});
        chk({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic push_exp(input string name, input logic [31:0] res, input logic [4:0] rd, input int lat);
    exp_t e;
    e.res   = res;
    e.wb_en = (rd != 5'd0);
    e.addr  = rd;
    e.lat   = lat;
    e.t0    = cyc;
    e.name  = name;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_addr  = rd;
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                        input int lat);
    int nbusy;
    @(negedge clk);
    drive(f3, a, b, rd);
    push_exp(name, res, rd, lat);
    nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) nbusy++;
      else break;
    end
    chk({name, "_busy_cycles"}, 32'(nbusy), 32'(lat));
    chk({name, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start    = 1'b0;
    bus.funct3   = 3'b000;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_addr  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy",    {31'b0, bus.busy},  32'd0);
    chk("reset_done",    {31'b0, bus.done},  32'd0);
    chk("reset_wb_en",   {31'b0, bus.wb_en}, 32'd0);
    chk("reset_result",  bus.result,         32'd0);
    chk("reset_wb_addr", {27'b0, bus.wb_addr}, 32'd0);

    run_op("mul_neg",   F3_MUL,    32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
    run_op("mulh_min",  F3_MULH,   32'h80000000,  32'h80000000, 5'd6,  32'h40000000, 33);
    run_op("mulhu_min", F3_MULHU,  32'h80000000,  32'h80000000, 5'd7,  32'h40000000, 33);
    run_op("mulhsu",    F3_MULHSU, 32'h80000000,  32'h80000000, 5'd8,  32'hC0000000, 33);
    run_op("div_neg",   F3_DIV,    32'hFFFFFFF9,  32'd2,        5'd9,  32'hFFFFFFFD, 33);
    run_op("rem_neg",   F3_REM,    32'hFFFFFFF9,  32'd2,        5'd10, 32'hFFFFFFFF, 33);
    run_op("divu",      F3_DIVU,   32'd100,       32'd7,        5'd11, 32'd14,       33);
    run_op("remu",      F3_REMU,   32'd100,       32'd7,        5'd12, 32'd2,        33);
    run_op("div_by0",   F3_DIV,    32'd100,       32'd0,        5'd13, 32'hFFFFFFFF, 1);
    run_op("rem_by0",   F3_REM,    32'd100,       32'd0,        5'd14, 32'h00000064, 1);
    run_op("div_ovf",   F3_DIV,    32'h80000000,  32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
    run_op("rem_ovf",   F3_REM,    32'h80000000,  32'hFFFFFFFF, 5'd16, 32'h00000000, 1);

    // In-flight input changes and a start held through DONE must be ignored.
    @(negedge clk);
    drive(F3_DIVU, 32'd100, 32'd7, 5'd0);
    push_exp("divu_rd0", 32'd14, 5'd0, 33);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        bus.start = 1'b0;
        break;
      end
      bus.start    = (i >= 28) ? 1'b1 : i[0];
      bus.rs1_data = 32'd5 + 32'(i);
      bus.funct3   = F3_MUL;
      bus.rd_addr  = 5'd9;
    end
    repeat (5) @(negedge clk);
    chk("divu_rd0_no_relaunch", {31'b0, bus.busy}, 32'd0);
    chk("divu_rd0_drained", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    drive(F3_MUL, 32'd3, 32'd5, 5'd4);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_pre_busy", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy",  {31'b0, bus.busy},  32'd0);
    chk("rst_async_done",  {31'b0, bus.done},  32'd0);
    chk("rst_async_wb_en", {31'b0, bus.wb_en}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_after_idle", {31'b0, bus.busy}, 32'd0);
    run_op("mul_after_rst", F3_MUL, 32'h00012345, 32'h00000010, 5'd3, 32'h00123450, 33);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
